// File: rtl/bin_frac_seq_div.sv
// Sequential sign-magnitude fraction divider: 7-bit operands, restoring division, one quotient bit per clock.
// Optional FRAC_DIV_ROUND_EN adds a guard-bit iteration and rounds the quotient magnitude (saturating at 63).
module bin_frac_seq_div (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] a,
  input  logic [6:0] b,
  output logic       busy,
  output logic       done,
  output logic [6:0] quotient,
  output logic [5:0] remainder,
  output logic       ovf,
  output logic       div0
);

`ifdef FRAC_DIV_ROUND_EN
  localparam logic [2:0] LAST_ITER = 3'd6;
`else
  localparam logic [2:0] LAST_ITER = 3'd5;
`endif

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state;
  logic       neg_reg;
  logic [5:0] mb_reg;
  logic [6:0] r_reg;
  logic [5:0] q_reg;
  logic [2:0] cnt_reg;
`ifdef FRAC_DIV_ROUND_EN
  logic [5:0] rem_trunc_reg;
  logic [6:0] q_sum;
`endif

  logic [6:0] r2;
  logic       ge;
  logic [6:0] r_next;
  logic [5:0] q_next;
  logic [5:0] mag_fin;
  logic [5:0] rem_fin;

  // One restoring step; R stays below mb, so the doubled value fits in 7 bits.
  always_comb begin
    r2      = r_reg << 1;
    ge      = (r2 >= {1'b0, mb_reg});
    r_next  = ge ? (r2 - {1'b0, mb_reg}) : r2;
    q_next  = {q_reg[4:0], ge};
`ifdef FRAC_DIV_ROUND_EN
    // On the guard iteration q_reg already holds all six quotient bits.
    q_sum   = {1'b0, q_reg} + {6'd0, ge};
    mag_fin = q_sum[6] ? 6'd63 : q_sum[5:0];
    rem_fin = rem_trunc_reg;
`else
    mag_fin = q_next;
    rem_fin = r_next[5:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      div0      <= 1'b0;
      quotient  <= 7'd0;
      remainder <= 6'd0;
      neg_reg   <= 1'b0;
      mb_reg    <= 6'd0;
      r_reg     <= 7'd0;
      q_reg     <= 6'd0;
      cnt_reg   <= 3'd0;
`ifdef FRAC_DIV_ROUND_EN
      rem_trunc_reg <= 6'd0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            done      <= 1'b0;
            ovf       <= 1'b0;
            div0      <= 1'b0;
            quotient  <= 7'd0;
            remainder <= 6'd0;
            neg_reg   <= a[6] ^ b[6];
            mb_reg    <= b[5:0];
            if (b[5:0] == 6'd0) begin
              div0  <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else if (a[5:0] >= b[5:0]) begin
              ovf   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              r_reg   <= {1'b0, a[5:0]};
              q_reg   <= 6'd0;
              cnt_reg <= 3'd0;
              busy    <= 1'b1;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          r_reg   <= r_next;
          q_reg   <= q_next;
          cnt_reg <= cnt_reg + 3'd1;
`ifdef FRAC_DIV_ROUND_EN
          if (cnt_reg == 3'd5) begin
            rem_trunc_reg <= r_next[5:0];
          end
`endif
          if (cnt_reg == LAST_ITER) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= {neg_reg && (mag_fin != 6'd0), mag_fin};
            remainder <= rem_fin;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_frac_seq_div.sv
// Randomized bench for bin_frac_seq_div: arithmetic reference model, per-cycle compare, directed spec vectors.
module tb_bin_frac_seq_div;

`ifdef FRAC_DIV_ROUND_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 6;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] a = 7'd0;
  logic [6:0] b = 7'd0;
  logic       busy, done, ovf, div0;
  logic [6:0] quotient;
  logic [5:0] remainder;

  bin_frac_seq_div dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .ovf(ovf), .div0(div0)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int errs  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       nrm;
    logic       ov;
    logic       dz;
    logic [6:0] q;
    logic [5:0] r;
  } res_t;

  // Plain arithmetic: ma*64 = q*mb + rem, guard bit is bit 0 of floor(ma*128/mb).
  function automatic res_t model(input logic [6:0] ta, input logic [6:0] tbv);
    res_t res;
    int ma, mb, qi, ri;
    res = '0;
    ma  = int'(ta[5:0]);
    mb  = int'(tbv[5:0]);
    if (mb == 0) res.dz = 1'b1;
    else if (ma >= mb) res.ov = 1'b1;
    else begin
      res.nrm = 1'b1;
      qi = (ma * 64) / mb;
      ri = ma * 64 - qi * mb;
`ifdef FRAC_DIV_ROUND_EN
      if (((ma * 128) / mb) % 2 == 1) qi++;
      if (qi > 63) qi = 63;
`endif
      res.q = {((ta[6] ^ tbv[6]) && qi != 0), 6'(qi)};
      res.r = 6'(ri);
    end
    return res;
  endfunction

  // Handshake model: an operation is accepted whenever start is high and no division is iterating.
  int   cyc = 0;
  int   m_start = 0;
  logic m_valid = 1'b0;
  res_t m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
    end else begin
      if (start && !(m_valid && m_res.nrm && (cyc - m_start - 1) < LAT)) begin
        m_valid <= 1'b1;
        m_start <= cyc;
        m_res   <= model(a, b);
        $display("[TB] op a=%b b=%b -> q=%b rem=%0d ovf=%0d div0=%0d", a, b,
                 model(a, b).q, model(a, b).r, model(a, b).ov, model(a, b).dz);
      end
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin : cmp
    automatic int   d = 0;
    automatic logic eb = 1'b0;
    automatic logic ed = 1'b0;
    if (rst_n && m_valid) begin
      d  = cyc - m_start - 1;
      eb = m_res.nrm && (d < LAT);
      ed = m_res.nrm ? (d >= LAT) : 1'b1;
    end
    chk("busy", int'(busy), int'(eb));
    chk("done", int'(done), int'(ed));
    if (ed) begin
      chk("quotient", int'(quotient), int'(m_res.q));
      chk("remainder", int'(remainder), int'(m_res.r));
      chk("ovf", int'(ovf), int'(m_res.ov));
      chk("div0", int'(div0), int'(m_res.dz));
    end else begin
      chk("ovf_idle", int'(ovf), 0);
      chk("div0_idle", int'(div0), 0);
      if (!rst_n || !m_valid) begin
        chk("quotient_idle", int'(quotient), 0);
        chk("remainder_idle", int'(remainder), 0);
      end
    end
  end

  task automatic run_op(input logic [6:0] ta, input logic [6:0] tbv, input int eq, input int er,
                        input int eov, input int edz, input int elat, input string nm);
    int n;
    @(posedge clk); #1;
    a = ta; b = tbv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, n, elat);
    chk({nm, "_q"}, int'(quotient), eq);
    chk({nm, "_rem"}, int'(remainder), er);
    chk({nm, "_ovf"}, int'(ovf), eov);
    chk({nm, "_div0"}, int'(div0), edz);
  endtask

  initial begin
    res_t p;
    int   q1;
`ifdef FRAC_DIV_ROUND_EN
    q1 = 43;
`else
    q1 = 42;
`endif
    // Pin the model to hand-computed values.
    p = model(7'b0100000, 7'b0110000);
    chk("model_t1_q", int'(p.q), q1);
    chk("model_t1_rem", int'(p.r), 32);
    p = model(7'b1010000, 7'b0100000);
    chk("model_t2_q", int'(p.q), 96);
    p = model(7'b1000000, 7'b0000011);
    chk("model_negzero_q", int'(p.q), 0);

    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    run_op(7'b0100000, 7'b0110000, q1, 32, 0, 0, LAT, "t1");
    run_op(7'b1010000, 7'b0100000, 96, 0, 0, 0, LAT, "t2");
    run_op(7'b0010101, 7'b1000000, 0, 0, 0, 1, 0, "div0");
    run_op(7'b0110000, 7'b0100000, 0, 0, 1, 0, 0, "ovf");
    run_op(7'b1000000, 7'b0000011, 0, 0, 0, 0, LAT, "negzero");

    // Reset in the middle of a division.
    @(posedge clk); #1;
    a = 7'b0100000; b = 7'b0110000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_q", int'(quotient), 0);
    chk("rst_rem", int'(remainder), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    run_op(7'b0100000, 7'b0110000, q1, 32, 0, 0, LAT, "t1_after_reset");

    // Random traffic, including starts while busy and operand changes mid-division.
    repeat (3000) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      b = 7'($urandom);
      if ($urandom_range(0, 15) == 0) b[5:0] = 6'd0;
      a = 7'($urandom);
      if ($urandom_range(0, 3) != 0)
        a[5:0] = (b[5:0] == 6'd0) ? 6'd0 : 6'($urandom_range(0, int'(b[5:0]) - 1));
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
